// File: rtl/pmmu_arbiter.sv
// pmmu_arbiter: shares the single Pmmu port between the CPU and the loader/debug port.
// Round-robin on ties, one access in flight, each access aborted after TIMEOUT cycles
// without mem_rdy_i. All Pmmu-side outputs and the done/err pulses are registered.
module pmmu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cpu_rd_i,
    input  logic                  cpu_wr_i,
    input  logic [DATA_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wd_i,
    input  logic [2:0]            cpu_funct3_i,
    input  logic                  ldr_rd_i,
    input  logic                  ldr_wr_i,
    input  logic [DATA_WIDTH-1:0] ldr_addr_i,
    input  logic [DATA_WIDTH-1:0] ldr_wd_i,
    input  logic [2:0]            ldr_funct3_i,
    input  logic                  mem_rdy_i,
    input  logic [DATA_WIDTH-1:0] mem_rd_i,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    output logic [2:0]            mem_funct3_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  cpu_busy_o,
    output logic                  cpu_done_o,
    output logic                  ldr_done_o,
    output logic                  err_o
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CPU_ACC = 2'd1;
    localparam logic [1:0] S_LDR_ACC = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // Timer counts ACC cycles already spent; abort on the TIMEOUT-th ACC cycle.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic                  last_cpu_q, last_cpu_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  mrd_q, mrd_d;
    logic                  mwr_q, mwr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  cpu_done_q, cpu_done_d;
    logic                  ldr_done_q, ldr_done_d;
    logic                  err_q, err_d;

    logic req_c, req_l, grant_cpu;

    assign req_c = cpu_rd_i | cpu_wr_i;
    assign req_l = ldr_rd_i | ldr_wr_i;
    // CPU wins when alone, or on a tie when the loader was served last.
    assign grant_cpu = req_c & (~req_l | ~last_cpu_q);

    // Next-state: arbitration in IDLE, completion/timeout in ACC, one settle cycle in DONE.
    always_comb begin
        state_d    = state_q;
        last_cpu_d = last_cpu_q;
        timer_d    = timer_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        funct3_d   = funct3_q;
        mrd_d      = mrd_q;
        mwr_d      = mwr_q;
        rdata_d    = rdata_q;
        cpu_done_d = 1'b0;
        ldr_done_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_c | req_l) begin
                    timer_d    = '0;
                    last_cpu_d = grant_cpu;
                    if (grant_cpu) begin
                        state_d  = S_CPU_ACC;
                        addr_d   = cpu_addr_i;
                        wd_d     = cpu_wd_i;
                        funct3_d = cpu_funct3_i;
                        // rd+wr together is a write
                        mrd_d    = cpu_rd_i & ~cpu_wr_i;
                        mwr_d    = cpu_wr_i;
                    end else begin
                        state_d  = S_LDR_ACC;
                        addr_d   = ldr_addr_i;
                        wd_d     = ldr_wd_i;
                        funct3_d = ldr_funct3_i;
                        mrd_d    = ldr_rd_i & ~ldr_wr_i;
                        mwr_d    = ldr_wr_i;
                    end
                end
            end
            S_CPU_ACC, S_LDR_ACC: begin
                if (mem_rdy_i || timer_q == TIMER_LAST) begin
                    state_d    = S_DONE;
                    mrd_d      = 1'b0;
                    mwr_d      = 1'b0;
                    cpu_done_d = (state_q == S_CPU_ACC);
                    ldr_done_d = (state_q == S_LDR_ACC);
                    err_d      = ~mem_rdy_i;
                    rdata_d    = mem_rdy_i ? mem_rd_i : '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset drops strobes and pulses immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            last_cpu_q <= 1'b1;
            timer_q    <= '0;
            addr_q     <= '0;
            wd_q       <= '0;
            funct3_q   <= '0;
            mrd_q      <= 1'b0;
            mwr_q      <= 1'b0;
            rdata_q    <= '0;
            cpu_done_q <= 1'b0;
            ldr_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_cpu_q <= last_cpu_d;
            timer_q    <= timer_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            funct3_q   <= funct3_d;
            mrd_q      <= mrd_d;
            mwr_q      <= mwr_d;
            rdata_q    <= rdata_d;
            cpu_done_q <= cpu_done_d;
            ldr_done_q <= ldr_done_d;
            err_q      <= err_d;
        end
    end

    assign mem_addr_o   = addr_q;
    assign mem_wd_o     = wd_q;
    assign mem_funct3_o = funct3_q;
    assign mem_rd_o     = mrd_q;
    assign mem_wr_o     = mwr_q;
    assign rd_data_o    = rdata_q;
    assign cpu_done_o   = cpu_done_q;
    assign ldr_done_o   = ldr_done_q;
    assign err_o        = err_q;
    // Released in the CPU's own DONE cycle so the ControlMatrix can advance.
    assign cpu_busy_o   = req_c & ~(state_q == S_DONE && last_cpu_q);
endmodule

// File: tb/tb_pmmu_arbiter.sv
// Randomized and directed bench for pmmu_arbiter against a transaction-level model:
// winner chosen from the round-robin rule, strobe length = min(latency, TIMEOUT).
module tb_pmmu_arbiter;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          cpu_rd_i, cpu_wr_i, ldr_rd_i, ldr_wr_i, mem_rdy_i;
    logic [DW-1:0] cpu_addr_i, cpu_wd_i, ldr_addr_i, ldr_wd_i, mem_rd_i;
    logic [2:0]    cpu_funct3_i, ldr_funct3_i;
    logic [DW-1:0] mem_addr_o, mem_wd_o, rd_data_o;
    logic [2:0]    mem_funct3_o;
    logic          mem_rd_o, mem_wr_o, cpu_busy_o, cpu_done_o, ldr_done_o, err_o;

    int  vectors = 0;
    int  miscompares = 0;
    bit  lg_cpu = 1'b1;  // model: who was granted last

    pmmu_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wd_i(cpu_wd_i), .cpu_funct3_i(cpu_funct3_i),
        .ldr_rd_i(ldr_rd_i), .ldr_wr_i(ldr_wr_i), .ldr_addr_i(ldr_addr_i),
        .ldr_wd_i(ldr_wd_i), .ldr_funct3_i(ldr_funct3_i),
        .mem_rdy_i(mem_rdy_i), .mem_rd_i(mem_rd_i),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_funct3_o(mem_funct3_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .rd_data_o(rd_data_o),
        .cpu_busy_o(cpu_busy_o), .cpu_done_o(cpu_done_o), .ldr_done_o(ldr_done_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        reset_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        lg_cpu  = 1'b1;
    endtask

    // Serve one access: expects the grant within a bounded wait, checks the latched
    // fields every ACC cycle, answers mem_rdy_i on ACC cycle 'lat' (never if lat > TO),
    // then checks the DONE cycle and drops the winner's request.
    task automatic do_access(input bit exp_cpu, input int lat, input logic [DW-1:0] rdata,
                             input bit mutate);
        logic [DW-1:0] e_addr, e_wd, e_rdata;
        logic [2:0]    e_f3;
        logic          e_rd, e_wr, e_err;
        bit            seen;
        int            n;
        e_addr = exp_cpu ? cpu_addr_i : ldr_addr_i;
        e_wd   = exp_cpu ? cpu_wd_i : ldr_wd_i;
        e_f3   = exp_cpu ? cpu_funct3_i : ldr_funct3_i;
        e_wr   = exp_cpu ? cpu_wr_i : ldr_wr_i;
        e_rd   = (exp_cpu ? cpu_rd_i : ldr_rd_i) & ~e_wr;
        n      = (lat <= TO) ? lat : TO;
        e_err  = (lat > TO);
        e_rdata = e_err ? '0 : rdata;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_rd_o | mem_wr_o) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL grant_wait: no strobe within 20 cycles (cpu=%0b)", exp_cpu);
            return;
        end
        for (int k = 1; k <= n; k++) begin
            vectors++;
            if ({mem_addr_o, mem_wd_o, mem_funct3_o, mem_rd_o, mem_wr_o,
                 cpu_done_o, ldr_done_o, err_o} !==
                {e_addr, e_wd, e_f3, e_rd, e_wr, 3'b000} ||
                (exp_cpu && cpu_busy_o !== 1'b1)) begin
                miscompares++;
                $display("FAIL acc_cycle%0d: addr=%h wd=%h f3=%0d rd=%0b wr=%0b dn=%0b%0b err=%0b busy=%0b exp addr=%h wd=%h f3=%0d rd=%0b wr=%0b",
                         k, mem_addr_o, mem_wd_o, mem_funct3_o, mem_rd_o, mem_wr_o,
                         cpu_done_o, ldr_done_o, err_o, cpu_busy_o, e_addr, e_wd, e_f3, e_rd, e_wr);
            end
            if (mutate && k == 1) begin
                if (exp_cpu) begin cpu_addr_i = 32'h20; cpu_wd_i = ~cpu_wd_i; cpu_funct3_i = ~cpu_funct3_i; end
                else begin ldr_addr_i = 32'h20; ldr_wd_i = ~ldr_wd_i; ldr_funct3_i = ~ldr_funct3_i; end
            end
            if (k == lat) begin mem_rdy_i = 1'b1; mem_rd_i = rdata; end
            @(negedge clk);
            mem_rdy_i = 1'b0;
            mem_rd_i  = $urandom;
        end
        // DONE cycle
        vectors++;
        if (mem_rd_o !== 1'b0 || mem_wr_o !== 1'b0 || cpu_done_o !== exp_cpu ||
            ldr_done_o !== !exp_cpu || err_o !== e_err || rd_data_o !== e_rdata ||
            (exp_cpu && cpu_busy_o !== 1'b0)) begin
            miscompares++;
            $display("FAIL done_cycle: rd=%0b wr=%0b cdn=%0b ldn=%0b err=%0b data=%h busy=%0b exp cdn=%0b err=%0b data=%h",
                     mem_rd_o, mem_wr_o, cpu_done_o, ldr_done_o, err_o, rd_data_o, cpu_busy_o,
                     exp_cpu, e_err, e_rdata);
        end
        lg_cpu = exp_cpu;
        if (exp_cpu) begin cpu_rd_i = 1'b0; cpu_wr_i = 1'b0; end
        else begin ldr_rd_i = 1'b0; ldr_wr_i = 1'b0; end
        @(negedge clk);
        // IDLE cycle: pulses were one cycle, nothing strobing yet
        vectors++;
        if ({cpu_done_o, ldr_done_o, err_o, mem_rd_o, mem_wr_o} !== 5'b0 || rd_data_o !== e_rdata) begin
            miscompares++;
            $display("FAIL idle_after: dn=%0b%0b err=%0b rd=%0b wr=%0b data=%h exp data=%h",
                     cpu_done_o, ldr_done_o, err_o, mem_rd_o, mem_wr_o, rd_data_o, e_rdata);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({mem_addr_o, mem_wd_o, mem_funct3_o, mem_rd_o, mem_wr_o, rd_data_o,
             cpu_busy_o, cpu_done_o, ldr_done_o, err_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: addr=%h wd=%h rd=%0b wr=%0b data=%h busy=%0b exp all 0",
                     mem_addr_o, mem_wd_o, mem_rd_o, mem_wr_o, rd_data_o, cpu_busy_o);
        end
    endtask

    task automatic test_cpu_read();
        cpu_rd_i = 1'b1; cpu_wr_i = 1'b0; cpu_addr_i = 32'hFFC; cpu_funct3_i = 3'b010;
        #1;
        vectors++;
        if (cpu_busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_waiting: got %0b exp 1", cpu_busy_o);
        end
        do_access(1'b1, 2, 32'h04082983, 1'b0);
    endtask

    task automatic test_tie_alternate();
        apply_reset();
        cpu_addr_i = 32'h100; ldr_addr_i = 32'h200;
        for (int i = 0; i < 4; i++) begin
            cpu_rd_i = 1'b1; ldr_rd_i = 1'b1;
            do_access(!lg_cpu, 1 + i, $urandom, 1'b0);
        end
        // the leftover request is served last
        do_access(!lg_cpu, 1, $urandom, 1'b0);
    endtask

    task automatic test_rw_both();
        ldr_rd_i = 1'b1; ldr_wr_i = 1'b1; ldr_addr_i = 32'h10; ldr_wd_i = 32'hDEADBEEF;
        ldr_funct3_i = 3'b010;
        do_access(1'b0, 3, 32'h1234, 1'b0);
    endtask

    task automatic test_timeout();
        cpu_rd_i = 1'b1; cpu_addr_i = 32'h80; cpu_funct3_i = 3'b000;
        do_access(1'b1, TO + 5, 32'hFFFF_FFFF, 1'b0);
        // rdy exactly on the last allowed cycle still completes
        ldr_wr_i = 1'b1; ldr_addr_i = 32'h84;
        do_access(1'b0, TO, 32'hCAFE, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        cpu_rd_i = 1'b1; cpu_addr_i = 32'h40;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_rd_o) seen = 1'b1;
        end
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        vectors++;
        if (!seen || {mem_addr_o, mem_rd_o, mem_wr_o, rd_data_o, cpu_done_o, ldr_done_o, err_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: seen=%0b addr=%h rd=%0b data=%h dn=%0b%0b err=%0b exp 0",
                     seen, mem_addr_o, mem_rd_o, rd_data_o, cpu_done_o, ldr_done_o, err_o);
        end
        @(negedge clk);
        vectors++;
        if ({cpu_done_o, ldr_done_o, err_o} !== 3'b0) begin
            miscompares++;
            $display("FAIL reset_no_done: dn=%0b%0b err=%0b exp 0", cpu_done_o, ldr_done_o, err_o);
        end
        reset_i = 1'b0;
        lg_cpu  = 1'b1;
        do_access(1'b1, 2, 32'h5555AAAA, 1'b0);
    endtask

    task automatic test_addr_hold();
        cpu_rd_i = 1'b1; cpu_addr_i = 32'h04; cpu_wd_i = 32'h0; cpu_funct3_i = 3'b010;
        do_access(1'b1, 5, 32'h7777, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int mode;
            bit w;
            mode = $urandom_range(0, 2);
            cpu_addr_i = $urandom; cpu_wd_i = $urandom; cpu_funct3_i = 3'($urandom);
            ldr_addr_i = $urandom; ldr_wd_i = $urandom; ldr_funct3_i = 3'($urandom);
            if (mode != 1) begin
                cpu_rd_i = 1'($urandom); cpu_wr_i = 1'($urandom);
                if (!cpu_wr_i) cpu_rd_i = 1'b1;
            end
            if (mode != 0) begin
                ldr_rd_i = 1'($urandom); ldr_wr_i = 1'($urandom);
                if (!ldr_wr_i) ldr_rd_i = 1'b1;
            end
            w = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : !lg_cpu;
            do_access(w, $urandom_range(1, TO + 2), $urandom, 1'b0);
            if (mode == 2) do_access(!w, $urandom_range(1, TO + 2), $urandom, 1'b0);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        {cpu_rd_i, cpu_wr_i, ldr_rd_i, ldr_wr_i, mem_rdy_i} = '0;
        {cpu_addr_i, cpu_wd_i, ldr_addr_i, ldr_wd_i, mem_rd_i} = '0;
        cpu_funct3_i = '0; ldr_funct3_i = '0;
        @(negedge clk);
        test_reset();
        test_cpu_read();
        test_tie_alternate();
        test_rw_both();
        test_timeout();
        test_reset_mid();
        test_addr_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
